// File: rtl/cam_capture.sv
// Camera capture front end: oversampled camera bus -> 16-bit pixels with sof/eol -> FWFT FIFO.
// Optional `CAM_CAPTURE_STATS_EN adds frame_count, line_count and line_pixels outputs.
module cam_capture #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 12
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             cam_xclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_dat,
    output logic [15:0]      pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             overflow,
    output logic             frame_done
`ifdef CAM_CAPTURE_STATS_EN
    ,
    output logic [15:0]      frame_count,
    output logic [CNT_W-1:0] line_count,
    output logic [CNT_W-1:0] line_pixels
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_VSYNC, S_FRAME} state_t;

    // One shared chain keeps xclk, vsync, href and data mutually aligned.
    logic [10:0] sync_q [SYNC_STAGES];
    logic        xs, vs, hs, xs_d, hs_d;
    logic [7:0]  ds;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            xs_d <= 1'b0;
            hs_d <= 1'b0;
        end else begin
            sync_q[0] <= {cam_xclk, cam_vsync, cam_href, cam_dat};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            xs_d <= xs;
            hs_d <= hs;
        end
    end

    assign {xs, vs, hs, ds} = sync_q[SYNC_STAGES-1];

    logic xrise, href_fall;
    assign xrise     = xs & ~xs_d;
    assign href_fall = hs_d & ~hs;

    state_t state, state_n;
    logic   sof_start, frame_end, in_frame;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n   = state;
        sof_start = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_IDLE:  if (enable && vs) state_n = S_VSYNC;
            S_VSYNC: begin
                if (!enable) state_n = S_IDLE;
                else if (!vs) begin
                    state_n   = S_FRAME;
                    sof_start = 1'b1;
                end
            end
            S_FRAME: if (vs) begin
                frame_end = 1'b1;
                state_n   = enable ? S_VSYNC : S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign in_frame = (state == S_FRAME);

    logic       phase, pix_done;
    logic [7:0] byte_hi;

    assign pix_done = in_frame & xrise & hs & phase;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase   <= 1'b0;
            byte_hi <= '0;
        end else if (!in_frame || !hs) begin
            phase <= 1'b0;
        end else if (xrise) begin
            phase <= ~phase;
            if (!phase) byte_hi <= ds;
        end
    end

    // Holding one pixel back lets eol be attached when href falls, with no lookahead.
    logic        hold_vld, hold_sof, sof_pend;
    logic [15:0] hold_pix;
    logic        req_push, req_eol;

    assign req_push = in_frame & hold_vld & (pix_done | href_fall | frame_end);
    assign req_eol  = ~pix_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_vld <= 1'b0;
            hold_sof <= 1'b0;
            hold_pix <= '0;
            sof_pend <= 1'b0;
        end else begin
            if (sof_start) sof_pend <= 1'b1;
            if (pix_done) begin
                hold_vld <= 1'b1;
                hold_pix <= {byte_hi, ds};
                hold_sof <= sof_pend;
                sof_pend <= 1'b0;
            end else if (in_frame && (href_fall || frame_end)) begin
                hold_vld <= 1'b0;
            end
        end
    end

    logic        push_q, push_sof_q, push_eol_q;
    logic [15:0] push_data_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            push_q      <= 1'b0;
            push_sof_q  <= 1'b0;
            push_eol_q  <= 1'b0;
            push_data_q <= '0;
            frame_done  <= 1'b0;
        end else begin
            push_q      <= req_push;
            push_sof_q  <= hold_sof;
            push_eol_q  <= req_eol;
            push_data_q <= hold_pix;
            frame_done  <= frame_end;
        end
    end

    logic [17:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, pop, wr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = ~empty & pix_ready;
    assign wr    = push_q & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wptr[AW-1:0]] <= {push_sof_q, push_eol_q, push_data_q};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)  wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push_q && full && !pop)            overflow <= 1'b1;
            else if (state == S_IDLE && !enable)   overflow <= 1'b0;
        end
    end

    // Gate the head entry so the unreset storage never leaks onto the outputs.
    assign pix_valid = ~empty;
    assign {pix_sof, pix_eol, pix_data} = empty ? 18'd0 : mem[rptr[AW-1:0]];

`ifdef CAM_CAPTURE_STATS_EN
    logic [CNT_W-1:0] cur_px, cur_lines;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_px      <= '0;
            cur_lines   <= '0;
            frame_count <= '0;
            line_count  <= '0;
            line_pixels <= '0;
        end else begin
            if (sof_start) begin
                cur_px    <= '0;
                cur_lines <= '0;
            end else if (req_push) begin
                if (req_eol) begin
                    line_pixels <= sat_inc(cur_px);
                    cur_px      <= '0;
                    cur_lines   <= sat_inc(cur_lines);
                end else begin
                    cur_px <= sat_inc(cur_px);
                end
            end
            if (frame_end) begin
                frame_count <= frame_count + 1'b1;
                line_count  <= (req_push && req_eol) ? sat_inc(cur_lines) : cur_lines;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cam_capture.sv
// Scoreboard bench for cam_capture: camera bus model enqueues expected pixels, monitor pops them.
module tb_cam_capture;

    logic        clk = 1'b0;
    logic        resetn, enable, cam_xclk, cam_vsync, cam_href, pix_ready;
    logic [7:0]  cam_dat;
    logic [15:0] pix_data;
    logic        pix_sof, pix_eol, pix_valid, overflow, frame_done;
`ifdef CAM_CAPTURE_STATS_EN
    logic [15:0] frame_count;
    logic [11:0] line_count, line_pixels;
`endif

    always #5 clk = ~clk;

    cam_capture dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .cam_xclk(cam_xclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_dat(cam_dat),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .overflow(overflow), .frame_done(frame_done)
`ifdef CAM_CAPTURE_STATS_EN
        , .frame_count(frame_count), .line_count(line_count), .line_pixels(line_pixels)
`endif
    );

    int          n_vec = 0, n_err = 0, fd_cnt = 0;
    int          limit = -1, en_line = -1;
    bit          sof_next;
    logic [17:0] q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && frame_done) fd_cnt++;
        if (resetn && pix_valid && pix_ready) begin
            chk("sb_has_entry", 32'(q.size() != 0), 1);
            if (q.size() != 0) chk("pixel", {pix_sof, pix_eol, pix_data}, q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic xcyc(input logic v, input logic h, input logic [7:0] d);
        cam_xclk = 1'b0; cam_vsync = v; cam_href = h; cam_dat = d;
        repeat (4) tick();
        cam_xclk = 1'b1;
        repeat (4) tick();
    endtask

    task automatic line(input int n, input logic [7:0] start, input bit exp);
        for (int i = 0; i < n; i++) begin
            if (exp && (i % 2 == 1)) begin
                if (limit != 0) begin
                    q.push_back({sof_next, (i / 2) == (n / 2 - 1),
                                 8'(start + 8'(i - 1)), 8'(start + 8'(i))});
                    if (limit > 0) limit--;
                end
                sof_next = 1'b0;
            end
            xcyc(1'b0, 1'b1, 8'(start + 8'(i)));
        end
    endtask

    task automatic frame(input int nl, input int nb, input logic [7:0] start, input bit exp);
        logic [7:0] b;
        int         fd0;
        b = start; fd0 = fd_cnt; sof_next = exp;
        repeat (3) xcyc(1'b1, 1'b0, 8'h00);
        repeat (2) xcyc(1'b0, 1'b0, 8'h00);
        for (int l = 0; l < nl; l++) begin
            if (l == en_line) enable = 1'b1;
            line(nb, b, exp);
            b = b + 8'(nb);
            repeat (2) xcyc(1'b0, 1'b0, 8'h00);
        end
        repeat (2) xcyc(1'b1, 1'b0, 8'h00);
        repeat (20) tick();
        chk("frame_done_cnt", fd_cnt - fd0, exp ? 1 : 0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk("drain_left", q.size(), 0);
        repeat (4) tick();
        chk("drain_valid", pix_valid, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; enable = 1'b0; pix_ready = 1'b1;
        cam_xclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_dat = 8'h00;
        repeat (5) tick();
        chk("rst_valid", pix_valid, 0);
        chk("rst_data", pix_data, 0);
        chk("rst_flags", {pix_sof, pix_eol, overflow, frame_done}, 0);
        resetn = 1'b1;
        repeat (5) tick();
        chk("idle_valid", pix_valid, 0);

        // 2 lines x 4 px, bytes 0x01..0x10
        enable = 1'b1;
        frame(2, 8, 8'h01, 1'b1);
        drain();

        // enable rises mid-frame: that frame skipped, next one captured with sof
        enable = 1'b0;
        repeat (10) tick();
        en_line = 1;
        frame(2, 8, 8'h30, 1'b0);
        en_line = -1;
        chk("skip_valid", pix_valid, 0);
        frame(2, 8, 8'h60, 1'b1);
        drain();

        // consumer stalled on a 6-px line: 4 kept, rest dropped
        pix_ready = 1'b0;
        limit = 4;
        frame(1, 12, 8'h20, 1'b1);
        chk("ovf_set", overflow, 1);
        chk("ovf_valid", pix_valid, 1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_stable", {pix_sof, pix_eol, pix_data}, {2'b10, 16'h2021});
            tick();
        end
        limit = -1;
        pix_ready = 1'b1;
        drain();
        chk("ovf_sticky", overflow, 1);
        enable = 1'b0;
        repeat (10) tick();
        chk("ovf_cleared", overflow, 0);
        enable = 1'b1;
        repeat (10) tick();

        // odd trailing byte dropped
        frame(1, 7, 8'h40, 1'b1);
        drain();
        chk("odd_no_ovf", overflow, 0);

        // reset mid-line with data in the FIFO
        pix_ready = 1'b0;
        repeat (3) xcyc(1'b1, 1'b0, 8'h00);
        repeat (2) xcyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) xcyc(1'b0, 1'b1, 8'(8'h80 + 8'(i)));
        chk("pre_rst_valid", pix_valid, 1);
        chk("pre_rst_sof", pix_sof, 1);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        chk("async_rst_valid", pix_valid, 0);
        chk("async_rst_data", pix_data, 0);
        chk("async_rst_flags", {pix_sof, pix_eol, overflow, frame_done}, 0);
        repeat (3) tick();
        resetn = 1'b1;
        pix_ready = 1'b1;
        repeat (2) xcyc(1'b0, 1'b0, 8'h00);
        frame(2, 8, 8'hA0, 1'b1);
        drain();

`ifdef CAM_CAPTURE_STATS_EN
        resetn = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        for (int f = 0; f < 3; f++) begin
            frame(2, 8, 8'(8'h10 * f), 1'b1);
            drain();
        end
        chk("frame_count", frame_count, 3);
        chk("line_count", line_count, 2);
        chk("line_pixels", line_pixels, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
